// File: rtl/urv_console_uart_if.sv
// rtl/urv_console_uart_if.sv - uRV dm_* data-memory bus between CPU and the console responder
interface urv_console_uart_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic [31:0] dm_data_l_o;
  logic        dm_store_done_o;
  logic        dm_load_done_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    input  dm_data_l_o, dm_store_done_o, dm_load_done_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    output dm_data_l_o, dm_store_done_o, dm_load_done_o
  );
endinterface

// File: rtl/urv_console_uart.sv
// rtl/urv_console_uart.sv - console/test-status window with TX FIFO and 8N1 UART
module urv_console_uart #(
  parameter int          g_clk_div    = 868,
  parameter int          g_fifo_depth = 16,
  parameter logic [31:0] g_base_addr  = 32'h00100000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  urv_console_uart_if.slave    dm,
  output logic                 txd_o,
  output logic                 test_done_o,
  output logic [31:0]          test_status_o
);

  localparam int AW = $clog2(g_fifo_depth);
  localparam int CW = $clog2(g_clk_div);
  localparam logic [AW:0]   c_depth  = (AW+1)'(g_fifo_depth);
  localparam logic [CW-1:0] c_div_m1 = CW'(g_clk_div - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [g_fifo_depth];
  logic [AW:0]   wptr, rptr, level;
  logic          full, empty, push, pop, overflow;
  logic [1:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter, rd_byte;
  logic          tx_busy;
  logic          hit, st, ld, tx_wr;
  logic [3:0]    off;
  logic [31:0]   status_word;
  logic          unused_sel;

  assign unused_sel = ^dm.dm_data_select_i[3:1];

  assign hit   = dm.dm_addr_i[31:4] == g_base_addr[31:4];
  assign off   = dm.dm_addr_i[3:0];
  assign st    = dm.dm_store_i & hit;
  assign ld    = dm.dm_load_i & hit & ~dm.dm_store_i;
  assign tx_wr = st & (off == 4'h0) & dm.dm_data_select_i[0];

  // Pointers carry one extra bit so level stays exact across rollover.
  assign level   = wptr - rptr;
  assign full    = level == c_depth;
  assign empty   = level == '0;
  assign rd_byte = mem[rptr[AW-1:0]];
  assign tx_busy = state != S_IDLE;
  assign pop     = ~empty & ((state == S_IDLE) | ((state == S_STOP) & (baud == '0)));
  assign push    = tx_wr & (~full | pop);

  assign status_word = {16'h0, 8'(level), 4'h0, overflow, tx_busy, empty, full};

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= dm.dm_data_s_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shifter <= '0;
      txd_o   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shifter <= rd_byte;
            baud    <= c_div_m1;
            txd_o   <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (baud == '0) begin
            baud    <= c_div_m1;
            bit_cnt <= '0;
            txd_o   <= shifter[0];
            shifter <= shifter >> 1;
            state   <= S_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_DATA: begin
          if (baud == '0) begin
            baud <= c_div_m1;
            if (bit_cnt == 3'd7) begin
              txd_o <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd_o   <= shifter[0];
              shifter <= shifter >> 1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          // Chain straight into the next start bit when more bytes are queued.
          if (baud == '0) begin
            if (pop) begin
              shifter <= rd_byte;
              baud    <= c_div_m1;
              txd_o   <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dm.dm_store_done_o <= 1'b0;
      dm.dm_load_done_o  <= 1'b0;
      dm.dm_data_l_o     <= '0;
      test_done_o        <= 1'b0;
      test_status_o      <= '0;
      overflow           <= 1'b0;
    end else begin
      dm.dm_store_done_o <= st;
      dm.dm_load_done_o  <= ld;
      if (tx_wr & full & ~pop) overflow <= 1'b1;
      if (st && off == 4'h4) begin
        test_done_o   <= 1'b1;
        test_status_o <= dm.dm_data_s_i;
      end
      if (st && off == 4'h8 && dm.dm_data_s_i[3]) overflow <= 1'b0;
      if (ld) begin
        case (off)
          4'h4:    dm.dm_data_l_o <= test_status_o;
          4'h8:    dm.dm_data_l_o <= status_word;
          default: dm.dm_data_l_o <= '0;
        endcase
      end
    end
  end

endmodule
